// File: rtl/cache_pkg.sv
// Shared parameters and state encoding for the cache/memory arbiter.
package cache_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_XFER_I,
        ARB_XFER_D,
        ARB_FINISH
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I- and D-cache
// line transfers; each grant moves a whole line beat by beat.
module cache_mem_arbiter
    import cache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [OFF_W-1:0]  d_word,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_t              r_state;
    logic [OFF_W-1:0]        r_beat;
    logic                    r_last_d;
    logic                    r_we;
    logic [ADDR_W-OFF_W-1:0] r_base;
    logic [DATA_W-1:0]       r_i_rdata;
    logic [DATA_W-1:0]       r_d_rdata;
    logic                    r_i_rvalid;
    logic                    r_d_rvalid;
    logic                    r_i_done;
    logic                    r_d_done;

    logic w_xfer;
    logic w_xfer_d;
    logic w_last;
    logic w_grant_d;

    assign w_xfer_d  = (r_state == ARB_XFER_D);
    assign w_xfer    = (r_state == ARB_XFER_I) || w_xfer_d;
    assign w_last    = (r_beat == OFF_W'(LINE_WORDS - 1));
    // D wins a tie unless it was the side served last
    assign w_grant_d = d_req && (!i_req || !r_last_d);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ARB_IDLE;
            r_beat     <= '0;
            r_last_d   <= 1'b0;
            r_we       <= 1'b0;
            r_base     <= '0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_done   <= 1'b0;
            r_d_done   <= 1'b0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_done   <= 1'b0;
            r_d_done   <= 1'b0;
            unique case (r_state)
                ARB_IDLE: begin
                    r_beat <= '0;
                    if (w_grant_d) begin
                        r_state <= ARB_XFER_D;
                        r_base  <= d_addr[ADDR_W-1:OFF_W];
                        r_we    <= d_we;
                    end else if (i_req) begin
                        r_state <= ARB_XFER_I;
                        r_base  <= i_addr[ADDR_W-1:OFF_W];
                        r_we    <= 1'b0;
                    end
                end
                ARB_XFER_I: begin
                    if (mem_ack) begin
                        r_beat     <= r_beat + OFF_W'(1);
                        r_i_rdata  <= mem_rdata;
                        r_i_rvalid <= 1'b1;
                        if (w_last) begin
                            r_state  <= ARB_FINISH;
                            r_i_done <= 1'b1;
                        end
                    end
                end
                ARB_XFER_D: begin
                    if (mem_ack) begin
                        r_beat <= r_beat + OFF_W'(1);
                        if (!r_we) begin
                            r_d_rdata  <= mem_rdata;
                            r_d_rvalid <= 1'b1;
                        end
                        if (w_last) begin
                            r_state  <= ARB_FINISH;
                            r_d_done <= 1'b1;
                        end
                    end
                end
                ARB_FINISH: begin
                    // d_done is high here exactly when D owned this line
                    r_last_d <= r_d_done;
                    r_state  <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign mem_req   = w_xfer;
    assign mem_we    = w_xfer_d && r_we;
    assign mem_addr  = w_xfer ? {r_base, r_beat} : '0;
    assign mem_wdata = w_xfer_d ? d_wdata : '0;
    assign d_word    = w_xfer_d ? r_beat : '0;

    assign i_rdata  = r_i_rdata;
    assign i_rvalid = r_i_rvalid;
    assign i_done   = r_i_done;
    assign d_rdata  = r_d_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_done   = r_d_done;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected beats, read data and
// line completions are queued at stimulus time and checked as they appear.
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    typedef struct {
        logic              d;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } beat_t;

    typedef struct {
        logic d;
        logic rd;
    } done_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rvalid;
    logic              i_done;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata;
    logic [OFF_W-1:0]  d_word;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;
    logic              d_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;

    beat_t             beat_q[$];
    done_t             done_q[$];
    logic [DATA_W-1:0] i_rd_q[$];
    logic [DATA_W-1:0] d_rd_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int acks = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit ack_noise = 1'b0;

    cache_mem_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_rvalid (i_rvalid),
        .i_done   (i_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_word   (d_word),
        .d_rdata  (d_rdata),
        .d_rvalid (d_rvalid),
        .d_done   (d_done),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    always #5 clock = ~clock;

    assign d_wdata = 16'hA000 + DATA_W'(d_word);

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic push_line(input logic d, input logic we,
                             input logic [ADDR_W-1:0] addr);
        beat_t e;
        done_t f;
        for (int b = 0; b < LINE_WORDS; b++) begin
            e.d     = d;
            e.we    = we;
            e.addr  = {addr[ADDR_W-1:OFF_W], OFF_W'(b)};
            e.wdata = d ? 16'hA000 + DATA_W'(b) : '0;
            beat_q.push_back(e);
        end
        f.d  = d;
        f.rd = !we;
        done_q.push_back(f);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_mreq"}, 32'(mem_req), 0);
        check_eq({tag, "_mwe"}, 32'(mem_we), 0);
        check_eq({tag, "_maddr"}, 32'(mem_addr), 0);
        check_eq({tag, "_mwdata"}, 32'(mem_wdata), 0);
        check_eq({tag, "_irdata"}, 32'(i_rdata), 0);
        check_eq({tag, "_drdata"}, 32'(d_rdata), 0);
        check_eq({tag, "_flags"},
                 32'({i_rvalid, i_done, d_rvalid, d_done, d_word}), 0);
    endtask

    task automatic wait_dones(input int target, output int cyc);
        cyc = 0;
        while (done_cnt < target) begin
            @(posedge clock);
            #2;
            cyc++;
            if (cyc > 300) begin
                check_eq("done_timeout", 32'(done_cnt), 32'(target));
                break;
            end
        end
    endtask

    task automatic wait_acks(input int target);
        int cyc;
        cyc = 0;
        while (acks < target) begin
            @(posedge clock);
            #2;
            cyc++;
            if (cyc > 300) begin
                check_eq("ack_timeout", 32'(acks), 32'(target));
                break;
            end
        end
    endtask

    // Memory model and output monitor, sampled 1 time unit after each edge
    initial begin
        beat_t e;
        done_t f;
        forever begin
            @(posedge clock);
            #1;
            if (i_rvalid) begin
                if (i_rd_q.size() == 0)
                    check_eq("i_rvalid_unexp", 32'(i_rdata), 32'hFFFF_FFFF);
                else
                    check_eq("i_rdata", 32'(i_rdata), 32'(i_rd_q.pop_front()));
            end
            if (d_rvalid) begin
                if (d_rd_q.size() == 0)
                    check_eq("d_rvalid_unexp", 32'(d_rdata), 32'hFFFF_FFFF);
                else
                    check_eq("d_rdata", 32'(d_rdata), 32'(d_rd_q.pop_front()));
            end
            if (i_done || d_done) begin
                if (done_q.size() == 0) begin
                    check_eq("done_unexp", 32'({d_done, i_done}), 0);
                end else begin
                    f = done_q.pop_front();
                    check_eq("done_side", 32'({d_done, i_done}),
                             f.d ? 32'd2 : 32'd1);
                    check_eq("done_rvalid",
                             32'(f.d ? d_rvalid : i_rvalid), 32'(f.rd));
                end
                done_cnt++;
            end
            if (mem_req) begin
                if (beat_q.size() == 0) begin
                    check_eq("beat_unexp", 32'(mem_addr), 32'hFFFF_FFFF);
                    mem_ack = 1'b0;
                end else begin
                    e = beat_q[0];
                    check_eq("mem_addr", 32'(mem_addr), 32'(e.addr));
                    check_eq("mem_we", 32'(mem_we), 32'(e.we));
                    check_eq("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                    check_eq("d_word", 32'(d_word),
                             e.d ? 32'(e.addr[OFF_W-1:0]) : 32'd0);
                    if (wait_cnt >= ack_delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_addr ^ 16'hC3C3;
                        if (!e.we) begin
                            if (e.d) d_rd_q.push_back(e.addr ^ 16'hC3C3);
                            else     i_rd_q.push_back(e.addr ^ 16'hC3C3);
                        end
                        void'(beat_q.pop_front());
                        acks++;
                        wait_cnt = 0;
                    end else begin
                        mem_ack = 1'b0;
                        wait_cnt++;
                    end
                end
            end else begin
                mem_ack   = ack_noise;
                mem_rdata = 16'hDEAD;
                wait_cnt  = 0;
            end
        end
    end

    initial begin
        int cyc;
        int base;
        int a0;

        repeat (2) @(posedge clock);
        #3;
        check_zero("rst");
        @(posedge clock);
        #2;
        reset = 1'b1;

        // both requests one cycle after reset: D first, dead cycle, then I
        @(posedge clock);
        #2;
        d_we   = 1'b0;
        d_addr = 16'h0041;
        i_addr = 16'h0162;
        push_line(1'b1, 1'b0, 16'h0040);
        push_line(1'b0, 1'b0, 16'h0160);
        d_req = 1'b1;
        i_req = 1'b1;
        base  = done_cnt;
        wait_dones(base + 1, cyc);
        d_req = 1'b0;
        check_eq("t2_d_lat", 32'(cyc), 5);
        wait_dones(base + 2, cyc);
        i_req = 1'b0;
        check_eq("t2_i_gap", 32'(cyc), 6);

        // continuous requests alternate D, I, D, I
        repeat (2) @(posedge clock);
        #2;
        d_addr = 16'h0300;
        i_addr = 16'h0200;
        push_line(1'b1, 1'b0, 16'h0300);
        push_line(1'b0, 1'b0, 16'h0200);
        push_line(1'b1, 1'b0, 16'h0300);
        push_line(1'b0, 1'b0, 16'h0200);
        d_req = 1'b1;
        i_req = 1'b1;
        base  = done_cnt;
        wait_dones(base + 4, cyc);
        d_req = 1'b0;
        i_req = 1'b0;
        check_eq("t6_lat", 32'(cyc), 23);

        // I refill, ack asserted every cycle even while idle
        repeat (2) @(posedge clock);
        #2;
        ack_noise = 1'b1;
        i_addr    = 16'h0123;
        push_line(1'b0, 1'b0, 16'h0123);
        i_req = 1'b1;
        base  = done_cnt;
        wait_dones(base + 1, cyc);
        i_req = 1'b0;
        check_eq("t1_lat", 32'(cyc), 5);
        @(posedge clock);
        #2;
        ack_noise = 1'b0;

        // D write-back, memory acks two cycles late on every beat
        repeat (2) @(posedge clock);
        #2;
        ack_delay = 2;
        d_we      = 1'b1;
        d_addr    = 16'h0080;
        push_line(1'b1, 1'b1, 16'h0080);
        d_req = 1'b1;
        base  = done_cnt;
        wait_dones(base + 1, cyc);
        d_req = 1'b0;
        d_we  = 1'b0;
        check_eq("t3_lat", 32'(cyc), 13);

        // D refill with request dropped after beat 1
        repeat (2) @(posedge clock);
        #2;
        ack_delay = 1;
        d_addr    = 16'h00C0;
        push_line(1'b1, 1'b0, 16'h00C0);
        d_req = 1'b1;
        a0    = acks;
        base  = done_cnt;
        wait_acks(a0 + 2);
        d_req = 1'b0;
        wait_dones(base + 1, cyc);
        check_eq("t4_done", 32'(done_cnt - base), 1);

        // reset during the beat 2 wait, then restart with i_req held
        repeat (2) @(posedge clock);
        #2;
        ack_delay = 2;
        i_addr    = 16'h0123;
        push_line(1'b0, 1'b0, 16'h0123);
        i_req = 1'b1;
        a0    = acks;
        wait_acks(a0 + 2);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_zero("t5_rst");
        beat_q.delete();
        done_q.delete();
        i_rd_q.delete();
        d_rd_q.delete();
        push_line(1'b0, 1'b0, 16'h0123);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        base  = done_cnt;
        wait_dones(base + 1, cyc);
        i_req = 1'b0;
        check_eq("t5_lat", 32'(cyc), 13);

        repeat (4) @(posedge clock);
        #2;
        check_eq("beat_q_left", 32'(beat_q.size()), 0);
        check_eq("done_q_left", 32'(done_q.size()), 0);
        check_eq("rd_q_left", 32'(i_rd_q.size() + d_rd_q.size()), 0);
        check_eq("idle_mreq", 32'(mem_req), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
